// File: rtl/sync_ctrl_pkg.sv
// Shared definitions for the synchronizer self-test sequencer: mode codes, FSM states,
// the stimulus pattern table and the mode_mask bit to mode-code mapping.
package sync_ctrl_pkg;

    localparam logic [2:0] MODE_REG  = 3'd0;
    localparam logic [2:0] MODE_CLK2 = 3'd1;
    localparam logic [2:0] MODE_2FF  = 3'd2;
    localparam logic [2:0] MODE_STB  = 3'd4;

    localparam int NUM_PATTERNS = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        DRIVE,
        STROBE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    function automatic logic [7:0] pattern_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h55;
            2'd1:    return 8'hFF;
            2'd2:    return 8'h00;
            default: return 8'hAA;
        endcase
    endfunction

    function automatic logic [2:0] mode_code(input logic [1:0] bit_idx);
        case (bit_idx)
            2'd0:    return MODE_REG;
            2'd1:    return MODE_CLK2;
            2'd2:    return MODE_2FF;
            default: return MODE_STB;
        endcase
    endfunction

endpackage

// File: rtl/sync_mode_sequencer_cycle_timer.sv
// Loadable down-counter with a zero flag; the sequencer reloads it on every state entry.
module cycle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sync_mode_sequencer.sv
// Self-test sequencer: walks the enabled datapath modes, drives the stimulus patterns,
// and counts mismatches between returned data and stimulus. All outputs are registered.
module sync_mode_sequencer
    import sync_ctrl_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int STB_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       mode_mask,
    input  logic [WIDTH-1:0] data_in,
    output logic [2:0]       sel,
    output logic             stb,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    localparam int MAX_A   = (SETUP_CYCLES > STB_CYCLES) ? SETUP_CYCLES : STB_CYCLES;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] LD_SETUP  = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] LD_STB    = TW'(STB_CYCLES - 1);
    localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYCLES - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] pattern_w(input logic [1:0] idx);
        return WIDTH'(pattern_byte(idx));
    endfunction

    state_t             r_state, w_state_nx;
    logic [2:0]         r_sel, w_sel_nx;
    logic               r_stb, w_stb_nx;
    logic [WIDTH-1:0]   r_dout, w_dout_nx;
    logic               r_busy, w_busy_nx;
    logic               r_done, w_done_nx;
    logic               r_pass, w_pass_nx;
    logic [ERR_W-1:0]   r_err, w_err_nx, w_err_chk;
    logic [1:0]         r_idx, w_idx_nx;
    logic [1:0]         r_bit, w_bit_nx;
    logic [3:0]         r_mask, w_mask_nx;
    logic [1:0]         w_first_bit, w_next_bit;
    logic               w_has_next;
    logic               w_zero, w_load;
    logic [TW-1:0]      w_load_val;

    cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Lowest enabled mode for a new run, and the next enabled mode above the current one.
    always_comb begin
        w_first_bit = 2'd0;
        w_next_bit  = r_bit;
        w_has_next  = 1'b0;
        for (int b = 3; b >= 0; b--) begin
            if (mode_mask[b]) w_first_bit = 2'(b);
            if (r_mask[b] && (b > int'(r_bit))) begin
                w_next_bit = 2'(b);
                w_has_next = 1'b1;
            end
        end
    end

    assign w_err_chk = (data_in != pattern_w(r_idx)) ? sat_inc(r_err) : r_err;

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_stb_nx   = 1'b0;
        w_dout_nx  = r_dout;
        w_busy_nx  = r_busy;
        w_done_nx  = r_done;
        w_pass_nx  = r_pass;
        w_err_nx   = r_err;
        w_idx_nx   = r_idx;
        w_bit_nx   = r_bit;
        w_mask_nx  = r_mask;
        case (r_state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    w_err_nx  = '0;
                    w_mask_nx = mode_mask;
                    if (mode_mask == 4'b0000) begin
                        w_state_nx = DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        w_pass_nx  = 1'b1;
                    end else begin
                        w_state_nx = SELECT;
                        w_busy_nx  = 1'b1;
                        w_done_nx  = 1'b0;
                        w_pass_nx  = 1'b0;
                        w_bit_nx   = w_first_bit;
                        w_sel_nx   = mode_code(w_first_bit);
                    end
                end
            end
            SELECT: begin
                if (w_zero) begin
                    w_state_nx = DRIVE;
                    w_idx_nx   = 2'd0;
                    w_dout_nx  = pattern_w(2'd0);
                end
            end
            DRIVE: begin
                if (w_zero) begin
                    if (r_sel == MODE_STB) begin
                        w_state_nx = STROBE;
                        w_stb_nx   = 1'b1;
                    end else begin
                        w_state_nx = SETTLE;
                    end
                end
            end
            STROBE: begin
                if (w_zero) w_state_nx = SETTLE;
                else        w_stb_nx   = 1'b1;
            end
            SETTLE: begin
                if (w_zero) w_state_nx = CHECK;
            end
            CHECK: begin
                w_err_nx = w_err_chk;
                if (r_idx != 2'(NUM_PATTERNS - 1)) begin
                    w_state_nx = DRIVE;
                    w_idx_nx   = r_idx + 2'd1;
                    w_dout_nx  = pattern_w(r_idx + 2'd1);
                end else if (w_has_next) begin
                    w_state_nx = SELECT;
                    w_bit_nx   = w_next_bit;
                    w_sel_nx   = mode_code(w_next_bit);
                end else begin
                    w_state_nx = DONE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_pass_nx  = (w_err_chk == '0);
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // Abort from any busy state behaves exactly like a reset of the outputs.
        if (abort && (r_state != IDLE) && (r_state != DONE)) begin
            w_state_nx = IDLE;
            w_sel_nx   = MODE_REG;
            w_stb_nx   = 1'b0;
            w_dout_nx  = '0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b0;
            w_pass_nx  = 1'b0;
            w_err_nx   = '0;
            w_idx_nx   = 2'd0;
            w_bit_nx   = 2'd0;
            w_mask_nx  = 4'b0000;
        end
    end

    always_comb begin
        w_load = (w_state_nx != r_state);
        case (w_state_nx)
            DRIVE:   w_load_val = LD_SETUP;
            STROBE:  w_load_val = LD_STB;
            SETTLE:  w_load_val = LD_SETTLE;
            default: w_load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= MODE_REG;
            r_stb   <= 1'b0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_idx   <= 2'd0;
            r_bit   <= 2'd0;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_stb   <= w_stb_nx;
            r_dout  <= w_dout_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_pass  <= w_pass_nx;
            r_err   <= w_err_nx;
            r_idx   <= w_idx_nx;
            r_bit   <= w_bit_nx;
            r_mask  <= w_mask_nx;
        end
    end

    assign sel       = r_sel;
    assign stb       = r_stb;
    assign data_out  = r_dout;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;

endmodule

// File: tb/tb_sync_mode_sequencer.sv
// Bench for sync_mode_sequencer: table of directed runs, abort/reset corners, and random
// mask/corruption runs scored against a run-level model (duration, error total, mode order).
module tb_sync_mode_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [3:0]   mask;
    logic [W-1:0] data_in, data_out, r_dly;
    logic [2:0]   sel;
    logic         stb, busy, done, pass;
    logic [3:0]   err_count;

    logic [2:0]   sel2;
    logic         stb2, busy2, done2, pass2;
    logic [W-1:0] dout2;
    logic [1:0]   err2;

    logic         stuck;
    logic [15:0]  corrupt;
    logic [1:0]   t_midx, t_pidx;

    int checks = 0;
    int failures = 0;

    sync_mode_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_mask(mask),
        .data_in(data_in), .sel(sel), .stb(stb), .data_out(data_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
    );

    sync_mode_sequencer #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_mask(mask),
        .data_in(8'h00), .sel(sel2), .stb(stb2), .data_out(dout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) r_dly <= data_out;

    // Loopback with optional single-bit corruption per (mode, pattern) slot.
    always_comb begin
        t_midx = 2'd0;
        t_pidx = 2'd0;
        case (sel)
            3'd1: t_midx = 2'd1;
            3'd2: t_midx = 2'd2;
            3'd4: t_midx = 2'd3;
            default: t_midx = 2'd0;
        endcase
        case (r_dly)
            8'hFF: t_pidx = 2'd1;
            8'h00: t_pidx = 2'd2;
            8'hAA: t_pidx = 2'd3;
            default: t_pidx = 2'd0;
        endcase
        if (stuck) data_in = 8'h00;
        else       data_in = r_dly ^ {7'd0, corrupt[{t_midx, t_pidx}]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Run-level reference model.
    function automatic int model_cycles(input logic [3:0] m);
        int c = 0;
        for (int b = 0; b < 4; b++)
            if (m[b]) c += 1 + 4 * (2 + 8 + 1) + ((b == 3) ? 4 * 2 : 0);
        return c;
    endfunction

    function automatic int model_errs(input logic [3:0] m, input logic stk,
                                      input logic [15:0] cor, input int maxv);
        int pats[4] = '{8'h55, 8'hFF, 8'h00, 8'hAA};
        int e = 0;
        for (int b = 0; b < 4; b++)
            for (int p = 0; p < 4; p++)
                if (m[b]) begin
                    if (stk) e += (pats[p] != 0) ? 1 : 0;
                    else     e += cor[b * 4 + p] ? 1 : 0;
                end
        return (e > maxv) ? maxv : e;
    endfunction

    task automatic run(input string tag, input logic [3:0] m, input logic stk,
                       input int exp_cyc, input int exp_err, input logic exp_pass,
                       input int pulse_at);
        int codes[4] = '{0, 1, 2, 4};
        logic [2:0] seen[$];
        int exp_sels[$];
        int n = 0, stb_cyc = 0, pulses = 0;
        logic prev_stb = 1'b0;
        logic [W-1:0] prev_do;
        int e2;
        @(negedge clk);
        mask = m; stuck = stk; start = 1'b1;
        prev_do = data_out;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && n < 400) begin
            if (data_out == 8'h55 && prev_do != 8'h55) seen.push_back(sel);
            prev_do = data_out;
            if (stb) begin
                stb_cyc++;
                if (!prev_stb) pulses++;
            end
            prev_stb = stb;
            start = (n == pulse_at);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        for (int b = 0; b < 4; b++) if (m[b]) exp_sels.push_back(codes[b]);
        chk({tag, ".cycles"}, n, exp_cyc);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".err"}, err_count, exp_err);
        chk({tag, ".pass"}, pass, exp_pass);
        chk({tag, ".nmodes"}, seen.size(), exp_sels.size());
        for (int i = 0; i < seen.size() && i < exp_sels.size(); i++)
            chk({tag, ".sel"}, seen[i], exp_sels[i]);
        chk({tag, ".stb_cyc"}, stb_cyc, m[3] ? 8 : 0);
        chk({tag, ".stb_pulses"}, pulses, m[3] ? 4 : 0);
        e2 = 3 * ((m[0] ? 1 : 0) + (m[1] ? 1 : 0) + (m[2] ? 1 : 0) + (m[3] ? 1 : 0));
        chk({tag, ".err2"}, err2, (e2 > 3) ? 3 : e2);
        chk({tag, ".pass2"}, pass2, (m == 4'b0000));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".sel"}, sel, 3'd0);
        chk({tag, ".stb"}, stb, 1'b0);
        chk({tag, ".data_out"}, data_out, 8'h00);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".pass"}, pass, 1'b0);
        chk({tag, ".err"}, err_count, 4'd0);
    endtask

    task automatic start_and_wait(input logic [3:0] m, input logic stk, input int cyc);
        @(negedge clk);
        mask = m; stuck = stk; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        logic       stuck;
        int         cyc;
        int         errs;
        logic       pass;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{4'b0001, 1'b0, 45, 0, 1'b1};
        tbl[1] = '{4'b1000, 1'b0, 53, 0, 1'b1};
        tbl[2] = '{4'b1111, 1'b1, 188, 12, 1'b0};
        tbl[3] = '{4'b0000, 1'b0, 0, 0, 1'b1};
        tbl[4] = '{4'b0110, 1'b1, 90, 6, 1'b0};
        tbl[5] = '{4'b1010, 1'b0, 98, 0, 1'b1};
        tbl[6] = '{4'b0100, 1'b1, 45, 3, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mask = 4'b0000;
        stuck = 1'b0; corrupt = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("reset");

        for (int i = 0; i < 7; i++)
            run($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].stuck, tbl[i].cyc,
                tbl[i].errs, tbl[i].pass, (i == 0) ? 20 : -1);

        // Abort in the first SETTLE of the 2FF mode (cycle 50 after start).
        start_and_wait(4'b0110, 1'b1, 50);
        chk("abort.pre_sel", sel, 3'd2);
        chk("abort.pre_err", err_count, 4'd3);
        chk("abort.pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_reset_vals("abort");
        repeat (3) @(posedge clk);
        #1;
        chk("abort.idle_busy", busy, 1'b0);
        run("after_abort", 4'b0110, 1'b0, 90, 0, 1'b1, -1);

        // start and abort together while idle-like: abort wins.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; abort = 1'b1; mask = 4'b0001;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort.busy", busy, 1'b0);
        chk("start_abort.done", done, 1'b0);

        // Synchronous reset in the middle of a run.
        start_and_wait(4'b1111, 1'b1, 100);
        chk("rst_mid.pre_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 10; r++) begin
            logic [3:0] m;
            int e;
            m = 4'($urandom_range(0, 15));
            corrupt = 16'($urandom);
            e = model_errs(m, 1'b0, corrupt, 15);
            run($sformatf("rand%0d", r), m, 1'b0, model_cycles(m), e, (e == 0), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
